// File: rtl/spy_memory_ctrl.sv
// Circular spy memory with freeze/clear, occupancy, sticky wrap flag and absolute/relative readout.
// Reads are 1-cycle registered and read-first. Frozen writes are refused and reported; there is no backpressure.
module spy_memory_ctrl #(
    parameter int PTR_WIDTH  = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  freeze,
    input  logic                  clear,
    input  logic                  read_enable,
    input  logic [PTR_WIDTH-1:0]  read_addr,
    input  logic                  read_relative,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic                  read_oob,
    output logic [PTR_WIDTH-1:0]  write_pointer,
    output logic [PTR_WIDTH:0]    occupancy,
    output logic                  looped,
    output logic                  write_dropped
);
    localparam int DEPTH = 2 ** PTR_WIDTH;
    localparam logic [PTR_WIDTH:0] FULL = (PTR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                 accept;
    logic                 refuse;
    logic [PTR_WIDTH-1:0] rd_index;
    logic                 rd_oob;

    always_comb begin
        accept = write_enable && !freeze && !clear;
        refuse = write_enable && freeze && !clear;
        // Relative offsets count back from the newest word, wrapping modulo DEPTH.
        if (read_relative) begin
            rd_index = write_pointer - PTR_WIDTH'(1) - read_addr;
            rd_oob   = {1'b0, read_addr} >= occupancy;
        end else begin
            rd_index = read_addr;
            rd_oob   = (occupancy < FULL) && (read_addr >= write_pointer);
        end
    end

    always_ff @(posedge clock) begin
        if (accept && !reset) begin
            mem[write_pointer] <= write_data;
        end
    end

    // Non-blocking read of mem gives read-first behaviour on a same-address collision.
    always_ff @(posedge clock) begin
        if (reset) begin
            read_data  <= '0;
            read_valid <= 1'b0;
            read_oob   <= 1'b0;
        end else begin
            read_valid <= read_enable;
            if (read_enable) begin
                read_data <= mem[rd_index];
                read_oob  <= rd_oob;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            write_pointer <= '0;
            occupancy     <= '0;
            looped        <= 1'b0;
            write_dropped <= 1'b0;
        end else begin
            write_dropped <= refuse;
            if (clear) begin
                write_pointer <= '0;
                occupancy     <= '0;
                looped        <= 1'b0;
            end else if (accept) begin
                write_pointer <= write_pointer + PTR_WIDTH'(1);
                if (occupancy != FULL) begin
                    occupancy <= occupancy + (PTR_WIDTH + 1)'(1);
                end
                if (write_pointer == {PTR_WIDTH{1'b1}}) begin
                    looped <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_spy_memory_ctrl.sv
// Bench for spy_memory_ctrl: a queue-free array model checked every cycle plus directed literal checks.
module tb_spy_memory_ctrl;
    localparam int PW    = 6;
    localparam int DW    = 32;
    localparam int DEPTH = 2 ** PW;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          write_enable = 1'b0;
    logic [DW-1:0] write_data = '0;
    logic          freeze = 1'b0;
    logic          clear = 1'b0;
    logic          read_enable = 1'b0;
    logic [PW-1:0] read_addr = '0;
    logic          read_relative = 1'b0;
    logic [DW-1:0] read_data;
    logic          read_valid;
    logic          read_oob;
    logic [PW-1:0] write_pointer;
    logic [PW:0]   occupancy;
    logic          looped;
    logic          write_dropped;

    spy_memory_ctrl #(.PTR_WIDTH(PW), .DATA_WIDTH(DW)) dut (
        .clock(clock), .reset(reset), .write_enable(write_enable), .write_data(write_data),
        .freeze(freeze), .clear(clear), .read_enable(read_enable), .read_addr(read_addr),
        .read_relative(read_relative), .read_data(read_data), .read_valid(read_valid),
        .read_oob(read_oob), .write_pointer(write_pointer), .occupancy(occupancy),
        .looped(looped), .write_dropped(write_dropped)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: plain integers and arrays describing what the buffer holds.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_known [DEPTH];
    int            m_wp = 0, m_occ = 0;
    bit            m_looped = 0;
    bit            e_valid = 0, e_oob = 0, e_drop = 0, e_known = 1, chk_en = 0;
    logic [DW-1:0] e_data = '0;

    task automatic model_step();
        int a;
        if (reset) begin
            m_wp = 0; m_occ = 0; m_looped = 0;
            e_valid = 0; e_oob = 0; e_drop = 0; e_data = '0; e_known = 1;
            chk_en = 1;
        end else begin
            e_valid = read_enable;
            if (read_enable) begin
                if (read_relative) begin
                    a     = (m_wp - 1 - int'(read_addr) + 2 * DEPTH) % DEPTH;
                    e_oob = int'(read_addr) >= m_occ;
                end else begin
                    a     = int'(read_addr);
                    e_oob = (m_occ < DEPTH) && (a >= m_wp);
                end
                e_known = m_known[a];
                e_data  = m_mem[a];
            end
            e_drop = write_enable && freeze && !clear;
            if (clear) begin
                m_wp = 0; m_occ = 0; m_looped = 0;
            end else if (write_enable && !freeze) begin
                m_mem[m_wp]   = write_data;
                m_known[m_wp] = 1;
                if (m_wp == DEPTH - 1) m_looped = 1;
                m_wp = (m_wp + 1) % DEPTH;
                if (m_occ < DEPTH) m_occ++;
            end
        end
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    initial forever begin
        @(negedge clock);
        if (chk_en) begin
            chk("m_valid", 64'(read_valid), 64'(e_valid));
            if (e_known) chk("m_data", 64'(read_data), 64'(e_data));
            if (e_valid) chk("m_oob", 64'(read_oob), 64'(e_oob));
            chk("m_drop", 64'(write_dropped), 64'(e_drop));
            chk("m_wp", 64'(write_pointer), 64'(m_wp));
            chk("m_occ", 64'(occupancy), 64'(m_occ));
            chk("m_looped", 64'(looped), 64'(m_looped));
        end
    end

    task automatic step();
        @(negedge clock);
    endtask

    task automatic wr(input logic [DW-1:0] d);
        write_enable = 1'b1;
        write_data   = d;
        step();
        write_enable = 1'b0;
    endtask

    task automatic rd(input logic rel, input int a, output logic [DW-1:0] d, output logic o);
        read_enable   = 1'b1;
        read_relative = rel;
        read_addr     = PW'(a);
        step();
        read_enable   = 1'b0;
        d = read_data;
        o = read_oob;
        chk("rd_valid", 64'(read_valid), 64'd1);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] d;
        logic          o;
        int            drops;

        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("rst_wp", 64'(write_pointer), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_looped", 64'(looped), 64'd0);
        chk("rst_data", 64'(read_data), 64'd0);
        chk("rst_valid", 64'(read_valid), 64'd0);
        chk("rst_oob", 64'(read_oob), 64'd0);
        chk("rst_drop", 64'(write_dropped), 64'd0);

        // Five words, then relative readout newest-first.
        for (int i = 0; i < 5; i++) wr(32'hA0 + 32'(i));
        chk("five_wp", 64'(write_pointer), 64'd5);
        chk("five_occ", 64'(occupancy), 64'd5);
        chk("five_looped", 64'(looped), 64'd0);
        for (int i = 0; i < 5; i++) begin
            rd(1'b1, i, d, o);
            chk("rel_data", 64'(d), 64'(32'hA4 - 32'(i)));
            chk("rel_oob", 64'(o), 64'd0);
        end
        rd(1'b1, 5, d, o);
        chk("rel5_oob", 64'(o), 64'd1);

        // Wrap: DEPTH+3 words valued 0..DEPTH+2 from an empty buffer.
        pulse_clear();
        for (int i = 0; i < DEPTH + 3; i++) begin
            wr(32'(i));
            chk("wrap_looped", 64'(looped), 64'(i + 1 >= DEPTH));
        end
        chk("wrap_occ", 64'(occupancy), 64'(DEPTH));
        chk("wrap_wp", 64'(write_pointer), 64'd3);
        rd(1'b0, 2, d, o);
        chk("abs2_data", 64'(d), 64'(DEPTH + 2));
        chk("abs2_oob", 64'(o), 64'd0);
        rd(1'b1, DEPTH - 1, d, o);
        chk("reloldest_data", 64'(d), 64'd3);

        // Frozen writes are refused one by one; reads keep working.
        freeze = 1'b1;
        drops  = 0;
        for (int i = 0; i < 4; i++) begin
            wr(32'hDEAD0000 + 32'(i));
            if (write_dropped) drops++;
        end
        chk("frz_drops", 64'(drops), 64'd4);
        chk("frz_wp", 64'(write_pointer), 64'd3);
        chk("frz_occ", 64'(occupancy), 64'(DEPTH));
        rd(1'b0, 2, d, o);
        chk("frz_read", 64'(d), 64'(DEPTH + 2));
        freeze = 1'b0;
        wr(32'h55);
        chk("unfrz_wp", 64'(write_pointer), 64'd4);

        // Collision at address 7 holding 0x11.
        pulse_clear();
        for (int i = 0; i < 8; i++) wr((i == 7) ? 32'h11 : 32'h70 + 32'(i));
        pulse_clear();
        for (int i = 0; i < 7; i++) wr(32'h80 + 32'(i));
        chk("col_wp", 64'(write_pointer), 64'd7);
        write_enable = 1'b1;
        write_data   = 32'h22;
        rd(1'b0, 7, d, o);
        write_enable = 1'b0;
        chk("col_old", 64'(d), 64'h11);
        rd(1'b0, 7, d, o);
        chk("col_new", 64'(d), 64'h22);
        chk("col_new_oob", 64'(o), 64'd0);

        // Clear racing a frozen write after ten writes: no drop, memory kept.
        pulse_clear();
        for (int i = 0; i < 10; i++) wr(32'hC0 + 32'(i));
        clear = 1'b1; write_enable = 1'b1; freeze = 1'b1; write_data = 32'hEE;
        step();
        clear = 1'b0; write_enable = 1'b0; freeze = 1'b0;
        chk("clr_wp", 64'(write_pointer), 64'd0);
        chk("clr_occ", 64'(occupancy), 64'd0);
        chk("clr_looped", 64'(looped), 64'd0);
        chk("clr_drop", 64'(write_dropped), 64'd0);
        rd(1'b0, 4, d, o);
        chk("clr_abs4", 64'(d), 64'hC4);
        chk("clr_abs4_oob", 64'(o), 64'd1);

        // Read in a clear cycle sees pre-clear state.
        for (int i = 0; i < 3; i++) wr(32'hB0 + 32'(i));
        clear = 1'b1;
        rd(1'b1, 0, d, o);
        clear = 1'b0;
        chk("rdclr_data", 64'(d), 64'hB2);
        chk("rdclr_oob", 64'(o), 64'd0);
        chk("rdclr_occ", 64'(occupancy), 64'd0);

        // Reset mid-stream with a read and a frozen write pending.
        for (int i = 0; i < 4; i++) wr(32'hE0 + 32'(i));
        reset = 1'b1; read_enable = 1'b1; write_enable = 1'b1; freeze = 1'b1;
        step();
        reset = 1'b0; read_enable = 1'b0; write_enable = 1'b0; freeze = 1'b0;
        chk("mrst_valid", 64'(read_valid), 64'd0);
        chk("mrst_data", 64'(read_data), 64'd0);
        chk("mrst_wp", 64'(write_pointer), 64'd0);
        chk("mrst_occ", 64'(occupancy), 64'd0);
        chk("mrst_looped", 64'(looped), 64'd0);
        chk("mrst_drop", 64'(write_dropped), 64'd0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spy_memory_ctrl.md
Name: spy_memory_ctrl

Overview:
Parametrised circular spy memory for the spy buffer path. It captures words from events in transit and adds the following over the plain circular store:
- freeze and clear control
- occupancy and sticky wrap tracking
- absolute or most-recent-relative readout, with a registered valid and an out-of-range flag

It sits between the spy buffer write tap and the readout/control interface.

Parameters:
PTR_WIDTH, 6, address width; depth DEPTH = 2**PTR_WIDTH entries
DATA_WIDTH, 32, width of each stored word

Ports:
clock  in  1  single system clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
write_enable  in  1  store write_data this cycle, unless frozen
write_data  in  DATA_WIDTH  word to store
freeze  in  1  level; while high, writes are blocked
clear  in  1  pulse; empties the buffer logically (pointers and flags only)
read_enable  in  1  issue a read this cycle
read_addr  in  PTR_WIDTH  absolute address, or age offset when read_relative=1
read_relative  in  1  0: address = read_addr; 1: address = write_pointer-1-read_addr (mod DEPTH)
read_data  out  DATA_WIDTH  registered read result
read_valid  out  1  one-cycle pulse; read_data updated this cycle
read_oob  out  1  qualified by read_valid; the addressed entry is not currently held
write_pointer  out  PTR_WIDTH  next address to be written
occupancy  out  PTR_WIDTH+1  valid entries held, 0..DEPTH
looped  out  1  sticky; set when the write pointer wraps DEPTH-1 -> 0
write_dropped  out  1  one-cycle pulse; a write was refused because freeze=1

Behaviour:
- Priority per cycle: reset > clear > write. Reads are independent of clear and write.
- Reset values: write_pointer=0, occupancy=0, looped=0, read_data=0, read_valid=0, read_oob=0, write_dropped=0. Memory contents are not reset.
- Accepted write: write_enable=1 and freeze=0 and clear=0.
  - Stores the word at memory[write_pointer].
  - write_pointer increments modulo DEPTH.
  - occupancy increments and saturates at DEPTH.
  - If write_pointer was DEPTH-1, looped is set on the same edge.
- Refused write: write_enable=1 and freeze=1 and clear=0. Memory, pointer and occupancy are unchanged; write_dropped=1 on the next cycle.
- Clear: write_pointer=0, occupancy=0, looped=0. Memory contents are retained. A write in the same cycle is discarded, and write_dropped is not asserted for it.
- Read latency is 1 cycle: read_enable at edge N gives read_data and read_valid=1 after edge N+1. read_valid=0 otherwise, and read_data holds its last value.
- Read address and read_oob are computed from pre-edge state (write_pointer, occupancy).
  - Relative mode: read_oob = (read_addr >= occupancy).
  - Absolute mode: read_oob = (occupancy < DEPTH) and (read_addr >= write_pointer).
- Read/write collision on the same address in the same cycle is read-first: read_data returns the old contents, never write_data.
- Relative offset 0 in a cycle with an accepted write returns the previous newest word, not the one being written.
- read_enable with reset=1 in the same cycle: no read_valid pulse.
- read_enable with clear=1 in the same cycle: the read is served with pre-clear state.
- Freeze does not block reads. Readout of a frozen buffer is the intended usage.
- Relative address arithmetic is PTR_WIDTH bits, wrapping modulo DEPTH.

Test Plan:
- Reset, then write 0xA0..0xA4 (5 words) -> write_pointer=5, occupancy=5, looped=0. Relative reads of offsets 0..4 return 0xA4,0xA3,0xA2,0xA1,0xA0, each with read_valid one cycle after its read_enable and read_oob=0. Relative offset 5 -> read_oob=1.
- Write DEPTH+3 words with values 0..DEPTH+2 -> looped goes high exactly on the edge of write number DEPTH, occupancy=DEPTH (saturated), write_pointer=3. Absolute read of address 2 returns DEPTH+2, read_oob=0. Relative offset DEPTH-1 returns 3.
- freeze=1 with 4 write attempts -> write_pointer and occupancy unchanged, write_dropped pulses 4 times, reads still return the pre-freeze data. Release freeze and write 1 word -> write_pointer increments by 1.
- Same-cycle absolute read and write of address write_pointer=7, where memory[7] holds 0x11 and write_data=0x22 -> read_data=0x11. A later read of address 7 returns 0x22.
- clear with a concurrent write after 10 writes -> write_pointer=0, occupancy=0, looped=0, no write_dropped. An absolute read of address 4 returns the old word with read_oob=1.
- reset asserted mid-stream with read_enable=1 in the same cycle -> next cycle read_valid=0, read_data=0, all status outputs at their reset values.
